ps2_packet_rx: RTL and testbench

Upstream receive front-end for the PS/2 mouse path. It conditions the raw MOUSE_CLOCK/MOUSE_DATA lines with a synchronizer and glitch filter, then deserializes 11-bit device-to-host frames with full start/parity/stop checking. It assembles validated bytes into 3-byte movement packets, delivering data_out/dav/m_ack to the position/status register stage. It replaces the unchecked shifter receiver and adds framing-error detection and packet resynchronization.

---
 rtl/ps2_packet_rx.sv | 165 ++++++++++++++++
 tb/tb_ps2_packet_rx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_packet_rx.sv
// PS/2 mouse receive front-end. It conditions the raw lines, deserializes and checks
// 11-bit frames, and assembles the validated bytes into 3-byte movement packets.
module ps2_packet_rx #(
   parameter int FILTER_LEN = 4,
   parameter int TIMEOUT    = 20000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MOUSE_CLOCK,
   input  logic        MOUSE_DATA,
   input  logic        enable,
   output logic [23:0] data_out,
   output logic        dav,
   output logic        m_ack,
   output logic        err
);
   localparam logic [3:0]  FCNT_LAST = 4'(FILTER_LEN - 1);
   localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   // Index 1 is the clock line, index 0 is the data line
   logic [1:0]      s1, s2, filt;
   logic [1:0][3:0] fcnt;
   logic            fe;

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1   <= '1;
         s2   <= '1;
         filt <= '1;
         fcnt <= '0;
         fe   <= 1'b0;
      end else begin
         s1 <= {MOUSE_CLOCK, MOUSE_DATA};
         s2 <= s1;
         for (int i = 0; i < 2; i++) begin
            if (s2[i] == filt[i])
               fcnt[i] <= '0;
            else if (fcnt[i] == FCNT_LAST) begin
               fcnt[i] <= '0;
               filt[i] <= ~filt[i];
            end else
               fcnt[i] <= fcnt[i] + 4'd1;
         end
         // Strobe lands in the same cycle the filtered clock first reads 0
         fe <= filt[1] && (s2[1] != filt[1]) && (fcnt[1] == FCNT_LAST);
      end
   end

   state_t      state, state_n;
   logic [2:0]  bit_cnt, bit_cnt_n;
   logic [7:0]  shreg, shreg_n;
   logic        par, par_n;
   logic [1:0]  idx, idx_n;
   logic [7:0]  b0, b0_n, b1, b1_n;
   logic [15:0] tcnt, tcnt_n;
   logic [23:0] data_n;
   logic        dav_n, err_n, mack_n;
   logic        data_f;

   assign data_f = filt[0];

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         shreg    <= '0;
         par      <= 1'b0;
         idx      <= '0;
         b0       <= '0;
         b1       <= '0;
         tcnt     <= '0;
         data_out <= '0;
         dav      <= 1'b0;
         err      <= 1'b0;
         m_ack    <= 1'b0;
      end else begin
         state    <= state_n;
         bit_cnt  <= bit_cnt_n;
         shreg    <= shreg_n;
         par      <= par_n;
         idx      <= idx_n;
         b0       <= b0_n;
         b1       <= b1_n;
         tcnt     <= tcnt_n;
         data_out <= data_n;
         dav      <= dav_n;
         err      <= err_n;
         m_ack    <= mack_n;
      end
   end

   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      shreg_n   = shreg;
      par_n     = par;
      idx_n     = idx;
      b0_n      = b0;
      b1_n      = b1;
      tcnt_n    = tcnt;
      data_n    = data_out;
      dav_n     = 1'b0;
      err_n     = 1'b0;
      mack_n    = m_ack;

      if (!enable) begin
         state_n = IDLE;
         idx_n   = '0;
         tcnt_n  = '0;
      end else if (fe) begin
         tcnt_n = '0;
         unique case (state)
            IDLE: begin
               if (!data_f) begin
                  state_n   = DATA;
                  bit_cnt_n = '0;
               end
            end
            DATA: begin
               shreg_n   = {data_f, shreg[7:1]};
               bit_cnt_n = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_n = PARITY;
            end
            PARITY: begin
               par_n   = data_f;
               state_n = STOP;
            end
            STOP: begin
               state_n = IDLE;
               if (!(^{shreg, par}) || !data_f) begin
                  err_n = 1'b1;
                  idx_n = '0;
               end else if (idx == 2'd0 && shreg == 8'hFA) begin
                  mack_n = 1'b1;
               end else if (idx == 2'd0 && !shreg[3]) begin
                  // Not a packet header: drop it so the stream can realign
                  idx_n = '0;
               end else begin
                  unique case (idx)
                     2'd0: begin b0_n = shreg; idx_n = 2'd1; end
                     2'd1: begin b1_n = shreg; idx_n = 2'd2; end
                     default: begin
                        data_n = {b0, b1, shreg};
                        dav_n  = 1'b1;
                        idx_n  = '0;
                     end
                  endcase
               end
            end
            default: state_n = IDLE;
         endcase
      end else if (state != IDLE || idx != 2'd0) begin
         if (tcnt == TO_LAST) begin
            state_n = IDLE;
            idx_n   = '0;
            tcnt_n  = '0;
            err_n   = 1'b1;
         end else
            tcnt_n = tcnt + 16'd1;
      end else
         tcnt_n = '0;
   end
endmodule

// File: tb/tb_ps2_packet_rx.sv
// Directed bench for ps2_packet_rx: a table of frames with expected packet results,
// followed by hand-written glitch, timeout, reset and enable sequences.
module tb_ps2_packet_rx;
   localparam int FLEN = 4;
   localparam int TOUT = 200;
   localparam int H    = 10;             // clk cycles per PS/2 clock half-period
   localparam int LAT  = 2 + FLEN + 1;   // negedges from raw stop-bit fall to dav/err

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        MOUSE_CLOCK = 1'b1;
   logic        MOUSE_DATA = 1'b1;
   logic        enable = 1'b0;
   logic [23:0] data_out;
   logic        dav, m_ack, err;

   int pass = 0, total = 0;
   int dav_cnt = 0, err_cnt = 0, both_cnt = 0;

   ps2_packet_rx #(.FILTER_LEN(FLEN), .TIMEOUT(TOUT)) dut (
      .clk(clk), .rst(rst), .MOUSE_CLOCK(MOUSE_CLOCK), .MOUSE_DATA(MOUSE_DATA),
      .enable(enable), .data_out(data_out), .dav(dav), .m_ack(m_ack), .err(err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (dav) dav_cnt++;
      if (err) err_cnt++;
      if (dav && err) both_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [7:0]  b;
      bit          par_ok;
      bit          stop_ok;
      bit          exp_dav;
      bit          exp_err;
      bit          exp_ack;
      logic [23:0] exp_data;
   } vec_t;

   vec_t vecs[18];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic send_bit(input logic d, output int ld, output int le);
      ld = -1;
      le = -1;
      @(negedge clk) MOUSE_DATA = d;
      repeat (H - 1) @(negedge clk);
      MOUSE_CLOCK = 1'b0;
      for (int i = 1; i <= H; i++) begin
         @(negedge clk);
         if (dav && ld < 0) ld = i;
         if (err && le < 0) le = i;
      end
      MOUSE_CLOCK = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok,
                             input int drop_at, output int ld, output int le);
      logic [10:0] bits;
      logic        p;
      p    = par_ok ? ~^b : ^b;
      bits = {stop_ok, p, b, 1'b0};
      for (int i = 0; i <= 10; i++) begin
         if (i == drop_at) enable = 1'b0;
         send_bit(bits[i], ld, le);
      end
      @(negedge clk) MOUSE_DATA = 1'b1;
      repeat (H) @(negedge clk);
      if (drop_at >= 0) enable = 1'b1;
   endtask

   task automatic send_ok(input logic [7:0] b);
      int ld, le;
      send_frame(b, 1'b1, 1'b1, -1, ld, le);
   endtask

   initial begin
      int ld, le, dc, ec;

      vecs[0]  = '{8'h08, 1, 1, 0, 0, 0, 24'h000000};
      vecs[1]  = '{8'h05, 1, 1, 0, 0, 0, 24'h000000};
      vecs[2]  = '{8'hFB, 1, 1, 1, 0, 0, 24'h0805FB};
      vecs[3]  = '{8'h28, 0, 1, 0, 1, 0, 24'h0805FB};
      vecs[4]  = '{8'h08, 1, 1, 0, 0, 0, 24'h0805FB};
      vecs[5]  = '{8'h01, 1, 1, 0, 0, 0, 24'h0805FB};
      vecs[6]  = '{8'h02, 1, 1, 1, 0, 0, 24'h080102};
      vecs[7]  = '{8'hFA, 1, 1, 0, 0, 1, 24'h080102};
      vecs[8]  = '{8'h09, 1, 1, 0, 0, 1, 24'h080102};
      vecs[9]  = '{8'h00, 1, 1, 0, 0, 1, 24'h080102};
      vecs[10] = '{8'h00, 1, 1, 1, 0, 1, 24'h090000};
      vecs[11] = '{8'h00, 1, 1, 0, 0, 1, 24'h090000};
      vecs[12] = '{8'h08, 1, 1, 0, 0, 1, 24'h090000};
      vecs[13] = '{8'h33, 1, 0, 0, 1, 1, 24'h090000};
      vecs[14] = '{8'h01, 1, 1, 0, 0, 1, 24'h090000};
      vecs[15] = '{8'h08, 1, 1, 0, 0, 1, 24'h090000};
      vecs[16] = '{8'h10, 1, 1, 0, 0, 1, 24'h090000};
      vecs[17] = '{8'h20, 1, 1, 1, 0, 1, 24'h081020};

      repeat (4) @(negedge clk);
      chk("reset data_out", 32'(data_out), 32'h0);
      chk("reset dav", 32'(dav), 32'h0);
      chk("reset m_ack", 32'(m_ack), 32'h0);
      chk("reset err", 32'(err), 32'h0);
      rst = 1'b1;
      enable = 1'b1;
      repeat (H) @(negedge clk);

      foreach (vecs[k]) begin
         dc = dav_cnt;
         ec = err_cnt;
         send_frame(vecs[k].b, vecs[k].par_ok, vecs[k].stop_ok, -1, ld, le);
         chk($sformatf("vec%0d dav count", k), 32'(dav_cnt - dc), 32'(vecs[k].exp_dav));
         chk($sformatf("vec%0d err count", k), 32'(err_cnt - ec), 32'(vecs[k].exp_err));
         if (vecs[k].exp_dav) chk($sformatf("vec%0d dav latency", k), 32'(ld), 32'(LAT));
         if (vecs[k].exp_err) chk($sformatf("vec%0d err latency", k), 32'(le), 32'(LAT));
         chk($sformatf("vec%0d m_ack", k), 32'(m_ack), 32'(vecs[k].exp_ack));
         chk($sformatf("vec%0d data_out", k), 32'(data_out), 32'(vecs[k].exp_data));
      end

      // Short low glitch on the clock with data low must not start a frame
      ec = err_cnt;
      dc = dav_cnt;
      @(negedge clk);
      MOUSE_DATA  = 1'b0;
      MOUSE_CLOCK = 1'b0;
      repeat (2) @(negedge clk);
      MOUSE_CLOCK = 1'b1;
      MOUSE_DATA  = 1'b1;
      repeat (2 * H) @(negedge clk);
      send_ok(8'h08);
      send_ok(8'h10);
      send_ok(8'h30);
      chk("glitch data_out", 32'(data_out), 32'h081030);
      chk("glitch err count", 32'(err_cnt - ec), 32'h0);
      chk("glitch dav count", 32'(dav_cnt - dc), 32'h1);

      // Partial packet abandoned by the timeout
      send_ok(8'h08);
      send_ok(8'h01);
      ec = err_cnt;
      dc = dav_cnt;
      repeat (TOUT + 100) @(negedge clk);
      chk("timeout err count", 32'(err_cnt - ec), 32'h1);
      chk("timeout dav count", 32'(dav_cnt - dc), 32'h0);
      send_ok(8'h08);
      send_ok(8'h03);
      send_ok(8'h04);
      chk("post-timeout data_out", 32'(data_out), 32'h080304);

      // Reset after start + 5 data bits of 0x18
      ec = err_cnt;
      dc = dav_cnt;
      send_bit(1'b0, ld, le);
      for (int i = 0; i < 5; i++) send_bit(8'h18 >> i & 8'h01, ld, le);
      @(negedge clk) rst = 1'b0;
      MOUSE_DATA = 1'b1;
      repeat (3) @(negedge clk);
      chk("midreset data_out", 32'(data_out), 32'h0);
      chk("midreset m_ack", 32'(m_ack), 32'h0);
      chk("midreset dav", 32'(dav), 32'h0);
      chk("midreset err", 32'(err), 32'h0);
      rst = 1'b1;
      repeat (2 * H) @(negedge clk);
      chk("midreset no pulses", 32'(err_cnt - ec + dav_cnt - dc), 32'h0);
      send_ok(8'h18);
      send_ok(8'hFF);
      dc = dav_cnt;
      send_frame(8'h01, 1'b1, 1'b1, -1, ld, le);
      chk("post-reset dav count", 32'(dav_cnt - dc), 32'h1);
      chk("post-reset data_out", 32'(data_out), 32'h18FF01);

      // Enable dropped mid-frame on the second byte: silent discard, index cleared
      ec = err_cnt;
      dc = dav_cnt;
      send_ok(8'h08);
      send_frame(8'h05, 1'b1, 1'b1, 4, ld, le);
      send_ok(8'h08);
      send_ok(8'h05);
      send_ok(8'h06);
      chk("enable data_out", 32'(data_out), 32'h080506);
      chk("enable err count", 32'(err_cnt - ec), 32'h0);
      chk("enable dav count", 32'(dav_cnt - dc), 32'h1);
      chk("dav with err", 32'(both_cnt), 32'h0);

      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
